// File: rtl/wb_pkg.sv
// Shared encodings for the writeback mux pipeline: extension modes and select width.
package wb_pkg;

  localparam int SELW = 4;

  typedef enum logic [2:0] {
    EXT_WORD   = 3'd0,
    EXT_BYTE_S = 3'd1,
    EXT_BYTE_U = 3'd2,
    EXT_HALF_S = 3'd3,
    EXT_HALF_U = 3'd4
  } ext_mode_e;

endpackage

// File: rtl/wb_extend.sv
// Lane extraction and sign/zero extension of the selected writeback value.
module wb_extend
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic [2:0]       mode_i,
  input  logic [1:0]       off_i,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o
);

  logic [31:0] lo32;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Byte and half lanes always come from the low 32 bits.
  if (WIDTH >= 32) begin : g_wide
    assign lo32 = val_i[31:0];
  end else begin : g_narrow
    assign lo32 = {{(32-WIDTH){1'b0}}, val_i};
  end

  assign byte_v = lo32[{off_i, 3'b000} +: 8];
  assign half_v = lo32[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (ext_mode_e'(mode_i))
      EXT_WORD:   data_o = val_i;
      EXT_BYTE_S: data_o = {{(WIDTH-8){byte_v[7]}}, byte_v};
      EXT_BYTE_U: data_o = {{(WIDTH-8){1'b0}}, byte_v};
      EXT_HALF_S: begin
        data_o = {{(WIDTH-16){half_v[15]}}, half_v};
        err_o  = off_i[0];
      end
      EXT_HALF_U: begin
        data_o = {{(WIDTH-16){1'b0}}, half_v};
        err_o  = off_i[0];
      end
      default:    err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_mux_pipe.sv
// Source select, lane extension and a one-entry valid/ready output register
// feeding the register-file write port, plus a saturating accept counter.
module wb_mux_pipe
  import wb_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          NSRC      = 9,
  parameter int          CONST_IDX = 5,
  parameter int unsigned CONST_VAL = 227
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       sel,
  input  logic [2:0]            ext_mode,
  input  logic [1:0]            byte_off,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  output logic [15:0]           xfer_cnt
);

  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] ext_data;
  logic             ext_err;
  logic             sel_err;
  logic             req_err;
  logic             accept;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (int'(sel) == i) sel_val = src_data[i*WIDTH +: WIDTH];
    end
    if (int'(sel) == CONST_IDX) sel_val = WIDTH'(CONST_VAL);
  end

  assign sel_err = (int'(sel) >= NSRC);

  wb_extend #(.WIDTH(WIDTH)) u_extend (
    .val_i  (sel_val),
    .mode_i (ext_mode),
    .off_i  (byte_off),
    .data_o (ext_data),
    .err_o  (ext_err)
  );

  assign req_err  = sel_err | ext_err;
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      err_d   = req_err;
      data_d  = req_err ? '0 : ext_data;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (out_ready) begin
      // Drain without refill: data is left in place, only valid drops.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_mux_pipe.sv
// Self-checking bench for wb_mux_pipe: directed vector table, hand sequences
// for backpressure/reset/saturation, and randomized traffic against a model.
module tb_wb_mux_pipe;

  localparam int W  = 32;
  localparam int NS = 9;

  logic            clk;
  logic            reset;
  logic [NS*W-1:0] src_data;
  logic [3:0]      sel;
  logic [2:0]      ext_mode;
  logic [1:0]      byte_off;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_err;
  logic [15:0]     xfer_cnt;

  wb_mux_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .src_data  (src_data),
    .sel       (sel),
    .ext_mode  (ext_mode),
    .byte_off  (byte_off),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .xfer_cnt  (xfer_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference state of the output register.
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_err;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of a request computed from the rules with plain arithmetic: {err, data}.
  function automatic logic [32:0] model(input logic [NS*W-1:0] s, input logic [3:0] sl,
                                        input logic [2:0] md, input logic [1:0] of);
    longint unsigned v, b;
    logic [NS*W-1:0] sh;
    if (int'(sl) >= NS || md > 3'd4 || ((md == 3'd3 || md == 3'd4) && of[0]))
      return {1'b1, 32'h0};
    if (sl == 4'd5) v = 227;
    else begin
      sh = s >> (int'(sl) * 32);
      v  = longint'(sh[31:0]);
    end
    case (md)
      3'd0: b = v;
      3'd1, 3'd2: begin
        b = (v >> (8 * int'(of))) % 256;
        if (md == 3'd1 && b >= 128) b = b + 64'hFFFF_FF00;
      end
      default: begin
        b = (v >> (16 * int'(of[1]))) % 65536;
        if (md == 3'd3 && b >= 32768) b = b + 64'hFFFF_0000;
      end
    endcase
    return {1'b0, b[31:0]};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock: predict, take the edge, update the model, compare just after.
  task automatic cycle();
    logic        acc;
    logic [32:0] r;
    acc = reset && in_valid && (!m_valid || out_ready);
    r   = model(src_data, sel, ext_mode, byte_off);
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1;
      m_err   = r[32];
      m_data  = r[31:0];
      if (m_cnt < 65535) m_cnt++;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("out_err",   64'(out_err),   64'(m_err));
    chk("xfer_cnt",  64'(xfer_cnt),  64'(m_cnt));
    chk("in_ready",  64'(in_ready),  64'(!m_valid || out_ready));
  endtask

  task automatic randomize_src();
    for (int i = 0; i < NS; i++) src_data[i*W +: W] = $urandom;
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [2:0]  mode;
    logic [1:0]  off;
    logic [31:0] src;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] held;
    int          cnt_before;

    vecs[0]  = '{4'd3, 3'd1, 2'd0, 32'h1234_80F0, 32'hFFFF_FFF0, 1'b0};
    vecs[1]  = '{4'd3, 3'd2, 2'd1, 32'h1234_80F0, 32'h0000_0080, 1'b0};
    vecs[2]  = '{4'd3, 3'd1, 2'd1, 32'h1234_80F0, 32'hFFFF_FF80, 1'b0};
    vecs[3]  = '{4'd2, 3'd3, 2'd2, 32'h1234_80F0, 32'h0000_1234, 1'b0};
    vecs[4]  = '{4'd2, 3'd3, 2'd0, 32'h1234_80F0, 32'hFFFF_80F0, 1'b0};
    vecs[5]  = '{4'd2, 3'd4, 2'd0, 32'h1234_80F0, 32'h0000_80F0, 1'b0};
    vecs[6]  = '{4'd5, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0000_00E3, 1'b0};
    vecs[7]  = '{4'd0, 3'd0, 2'd3, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0};
    vecs[8]  = '{4'd9, 3'd0, 2'd0, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[9]  = '{4'd1, 3'd4, 2'd1, 32'h2222_2222, 32'h0000_0000, 1'b1};
    vecs[10] = '{4'd1, 3'd6, 2'd0, 32'h3333_3333, 32'h0000_0000, 1'b1};
    vecs[11] = '{4'd8, 3'd2, 2'd3, 32'h7F00_0000, 32'h0000_007F, 1'b0};
    vecs[12] = '{4'd5, 3'd2, 2'd0, 32'h0000_0000, 32'h0000_00E3, 1'b0};
    vecs[13] = '{4'd5, 3'd1, 2'd0, 32'h0000_0000, 32'hFFFF_FFE3, 1'b0};

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = '0;
    ext_mode  = '0;
    byte_off  = '0;
    src_data  = '0;
    randomize_src();
    model_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_out_err",   64'(out_err),   64'(0));
    chk("rst_xfer_cnt",  64'(xfer_cnt),  64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));

    // Requests offered while reset is held must be ignored.
    in_valid = 1'b1;
    sel      = 4'd3;
    repeat (2) cycle();
    @(negedge clk);
    reset = 1'b1;

    // Directed table; the first vector also checks the first edge after reset.
    for (int i = 0; i < 14; i++) begin
      randomize_src();
      if (vecs[i].sel < 4'd9) src_data[int'(vecs[i].sel)*W +: W] = vecs[i].src;
      sel       = vecs[i].sel;
      ext_mode  = vecs[i].mode;
      byte_off  = vecs[i].off;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      if (i == 8) cnt_before = int'(xfer_cnt);
      cycle();
      chk($sformatf("vec%0d_data", i),  64'(out_data),  64'(vecs[i].exp_data));
      chk($sformatf("vec%0d_err", i),   64'(out_err),   64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
      if (i == 10) chk("illegal_cnt_delta", 64'(int'(xfer_cnt) - cnt_before), 64'(3));
    end

    // Backpressure: hold for three cycles, then refill with no bubble.
    sel = 4'd4; ext_mode = 3'd0; byte_off = 2'd0;
    cycle();
    held      = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_src();
      sel      = 4'($urandom_range(0, 8));
      ext_mode = 3'($urandom_range(0, 4));
      cycle();
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_data",     64'(out_data), 64'(held));
    end
    out_ready = 1'b1;
    sel = 4'd6; ext_mode = 3'd0;
    cycle();
    chk("b2b_valid", 64'(out_valid), 64'(1));
    sel = 4'd7;
    cycle();
    chk("b2b_valid2", 64'(out_valid), 64'(1));
    held     = out_data;
    in_valid = 1'b0;
    cycle();
    chk("drain_valid", 64'(out_valid), 64'(0));
    chk("drain_data",  64'(out_data),  64'(held));

    // Reset while a result is held under backpressure.
    in_valid = 1'b1; sel = 4'd3; ext_mode = 3'd0;
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cycle();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_valid",    64'(out_valid), 64'(0));
    chk("midrst_data",     64'(out_data),  64'(0));
    chk("midrst_err",      64'(out_err),   64'(0));
    chk("midrst_cnt",      64'(xfer_cnt),  64'(0));
    chk("midrst_in_ready", 64'(in_ready),  64'(1));
    in_valid = 1'b1;
    repeat (2) cycle();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("post_rst_accept", 64'(out_valid), 64'(1));

    // Randomized traffic, including input changes while stalled.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) randomize_src();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      sel       = 4'($urandom_range(0, 15));
      ext_mode  = 3'($urandom_range(0, 7));
      byte_off  = 2'($urandom_range(0, 3));
      cycle();
    end

    // Counter saturation: run to FFFE at full throughput, then three more accepts.
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sel       = 4'd2;
    ext_mode  = 3'd0;
    byte_off  = 2'd0;
    repeat (65534) @(posedge clk);
    m_cnt   = 65534;
    m_valid = 1'b1;
    {m_err, m_data} = model(src_data, sel, ext_mode, byte_off);
    #1;
    chk("cnt_fffe", 64'(xfer_cnt), 64'h0000_FFFE);
    repeat (3) cycle();
    chk("cnt_sat", 64'(xfer_cnt), 64'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
